// File: rtl/ahb_ram_arbiter.sv
// Two-master AHB-Lite arbiter in front of a single-port AHB RAM.
// Master 0 is instruction fetch and master 1 is load/store. A request that
// loses arbitration, or that arrives while the RAM is busy, is parked in a
// hold register. Its master is stalled through HREADYOUTx until the parked
// request is issued. Ties are broken round-robin. A request that is not
// contended is forwarded in the same cycle.
module ahb_ram_arbiter #(
   parameter int AW = 16
) (
   input  logic          HCLK,
   input  logic          HRESET,
   input  logic          HSEL0,
   input  logic [AW-1:0] HADDR0,
   input  logic [1:0]    HTRANS0,
   input  logic [2:0]    HSIZE0,
   input  logic          HWRITE0,
   input  logic [31:0]   HWDATA0,
   input  logic          HREADY0,
   output logic          HREADYOUT0,
   output logic [31:0]   HRDATA0,
   output logic          HRESP0,
   input  logic          HSEL1,
   input  logic [AW-1:0] HADDR1,
   input  logic [1:0]    HTRANS1,
   input  logic [2:0]    HSIZE1,
   input  logic          HWRITE1,
   input  logic [31:0]   HWDATA1,
   input  logic          HREADY1,
   output logic          HREADYOUT1,
   output logic [31:0]   HRDATA1,
   output logic          HRESP1,
   output logic          HSEL_S,
   output logic [AW-1:0] HADDR_S,
   output logic [1:0]    HTRANS_S,
   output logic [2:0]    HSIZE_S,
   output logic          HWRITE_S,
   output logic [31:0]   HWDATA_S,
   output logic          HREADY_S,
   input  logic          HREADYOUT_S,
   input  logic [31:0]   HRDATA_S,
   input  logic          HRESP_S
);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_M0   = 2'd1,
      OWN_M1   = 2'd2
   } own_t;

   logic          sel_in    [2];
   logic          rdy_in    [2];
   logic [1:0]    trans_in  [2];
   logic [AW-1:0] addr_in   [2];
   logic [2:0]    size_in   [2];
   logic          write_in  [2];
   logic [AW-1:0] hold_addr [2];
   logic [2:0]    hold_size [2];

   logic [1:0] live;
   logic [1:0] req;
   logic [1:0] gnt;
   logic [1:0] pend;
   logic [1:0] hold_write;
   logic [1:0] own_is;
   logic [1:0] rdy_out;
   logic [1:0] resp_out;

   logic rr_ptr_reg;
   logic rr_ptr_next;
   own_t own_reg;
   own_t own_next;

   assign sel_in[0]   = HSEL0;
   assign sel_in[1]   = HSEL1;
   assign rdy_in[0]   = HREADY0;
   assign rdy_in[1]   = HREADY1;
   assign trans_in[0] = HTRANS0;
   assign trans_in[1] = HTRANS1;
   assign addr_in[0]  = HADDR0;
   assign addr_in[1]  = HADDR1;
   assign size_in[0]  = HSIZE0;
   assign size_in[1]  = HSIZE1;
   assign write_in[0] = HWRITE0;
   assign write_in[1] = HWRITE1;

   assign own_is = {own_reg == OWN_M1, own_reg == OWN_M0};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_master
         logic          pend_reg;
         logic [AW-1:0] haddr_reg;
         logic [2:0]    hsize_reg;
         logic          hwrite_reg;

         assign live[gi] = sel_in[gi] & rdy_in[gi] & trans_in[gi][1];
         assign req[gi]  = pend_reg | live[gi];

         // Park a live request that cannot be issued this cycle; drop it once granted.
         always_ff @(posedge HCLK or posedge HRESET) begin
            if (HRESET) begin
               pend_reg   <= 1'b0;
               haddr_reg  <= '0;
               hsize_reg  <= '0;
               hwrite_reg <= 1'b0;
            end else if (gnt[gi]) begin
               pend_reg <= 1'b0;
            end else if (live[gi]) begin
               pend_reg   <= 1'b1;
               haddr_reg  <= addr_in[gi];
               hsize_reg  <= size_in[gi];
               hwrite_reg <= write_in[gi];
            end
         end

         assign pend[gi]       = pend_reg;
         assign hold_addr[gi]  = haddr_reg;
         assign hold_size[gi]  = hsize_reg;
         assign hold_write[gi] = hwrite_reg;

         // Owner sees the RAM's ready; a parked master is stalled; others are idle-ready.
         assign rdy_out[gi]  = own_is[gi] ? HREADYOUT_S : ~pend_reg;
         assign resp_out[gi] = own_is[gi] & HRESP_S;
      end
   endgenerate

   // Grant only while the RAM can accept an address phase; ties go to rr_ptr.
   always_comb begin
      gnt = 2'b00;
      if (!HRESET && HREADYOUT_S) begin
         if (req == 2'b11) begin
            gnt = rr_ptr_reg ? 2'b10 : 2'b01;
         end else begin
            gnt = req;
         end
      end
   end

   // Round-robin pointer and data-phase owner: next-state logic.
   always_comb begin
      rr_ptr_next = rr_ptr_reg;
      own_next    = own_reg;
      if (gnt[0]) begin
         rr_ptr_next = 1'b1;
      end else if (gnt[1]) begin
         rr_ptr_next = 1'b0;
      end
      if (HREADYOUT_S) begin
         if (gnt[0]) begin
            own_next = OWN_M0;
         end else if (gnt[1]) begin
            own_next = OWN_M1;
         end else begin
            own_next = OWN_NONE;
         end
      end
   end

   // Round-robin pointer and data-phase owner: state registers.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         rr_ptr_reg <= 1'b0;
         own_reg    <= OWN_NONE;
      end else begin
         rr_ptr_reg <= rr_ptr_next;
         own_reg    <= own_next;
      end
   end

   // Address phase to the RAM. A replayed request is always NONSEQ, because its
   // burst context was broken by the other master.
   always_comb begin
      HSEL_S   = 1'b0;
      HADDR_S  = '0;
      HTRANS_S = 2'b00;
      HSIZE_S  = 3'b000;
      HWRITE_S = 1'b0;
      for (int i = 0; i < 2; i++) begin
         if (gnt[i]) begin
            HSEL_S = 1'b1;
            if (pend[i]) begin
               HADDR_S  = hold_addr[i];
               HTRANS_S = 2'b10;
               HSIZE_S  = hold_size[i];
               HWRITE_S = hold_write[i];
            end else begin
               HADDR_S  = addr_in[i];
               HTRANS_S = trans_in[i];
               HSIZE_S  = size_in[i];
               HWRITE_S = write_in[i];
            end
         end
      end
   end

   // Write data follows the data-phase owner.
   always_comb begin
      HWDATA_S = 32'h0;
      case (own_reg)
         OWN_M0:  HWDATA_S = HWDATA0;
         OWN_M1:  HWDATA_S = HWDATA1;
         default: HWDATA_S = 32'h0;
      endcase
   end

   assign HREADYOUT0 = rdy_out[0];
   assign HREADYOUT1 = rdy_out[1];
   assign HRESP0     = resp_out[0];
   assign HRESP1     = resp_out[1];
   assign HRDATA0    = HRDATA_S;
   assign HRDATA1    = HRDATA_S;
   assign HREADY_S   = HREADYOUT_S;

endmodule

// File: tb/tb_ahb_ram_arbiter.sv
// Bench for ahb_ram_arbiter: directed master traffic, a wait-state RAM model,
// and a transaction-level reference model checked on every cycle.
module tb_ahb_ram_arbiter;
   localparam int AW = 16;

   logic HCLK   = 1'b0;
   logic HRESET = 1'b1;

   logic          bsel [2];
   logic [1:0]    btr  [2];
   logic [AW-1:0] badr [2];
   logic [2:0]    bsz  [2];
   logic          bwr  [2];
   logic [31:0]   bwd  [2];

   logic          HREADYOUT0, HREADYOUT1, HRESP0, HRESP1;
   logic [31:0]   HRDATA0, HRDATA1;
   logic          HSEL_S, HWRITE_S, HREADY_S, HREADYOUT_S, HRESP_S;
   logic [AW-1:0] HADDR_S;
   logic [1:0]    HTRANS_S;
   logic [2:0]    HSIZE_S;
   logic [31:0]   HWDATA_S, HRDATA_S;

   int total = 0;
   int bad   = 0;

   always #5 HCLK = ~HCLK;

   ahb_ram_arbiter #(.AW(AW)) dut (
      .HCLK(HCLK), .HRESET(HRESET),
      .HSEL0(bsel[0]), .HADDR0(badr[0]), .HTRANS0(btr[0]), .HSIZE0(bsz[0]),
      .HWRITE0(bwr[0]), .HWDATA0(bwd[0]), .HREADY0(HREADYOUT0),
      .HREADYOUT0(HREADYOUT0), .HRDATA0(HRDATA0), .HRESP0(HRESP0),
      .HSEL1(bsel[1]), .HADDR1(badr[1]), .HTRANS1(btr[1]), .HSIZE1(bsz[1]),
      .HWRITE1(bwr[1]), .HWDATA1(bwd[1]), .HREADY1(HREADYOUT1),
      .HREADYOUT1(HREADYOUT1), .HRDATA1(HRDATA1), .HRESP1(HRESP1),
      .HSEL_S(HSEL_S), .HADDR_S(HADDR_S), .HTRANS_S(HTRANS_S), .HSIZE_S(HSIZE_S),
      .HWRITE_S(HWRITE_S), .HWDATA_S(HWDATA_S), .HREADY_S(HREADY_S),
      .HREADYOUT_S(HREADYOUT_S), .HRDATA_S(HRDATA_S), .HRESP_S(HRESP_S)
   );

   // ---------------- RAM model: word memory with ws_n wait states ----------------
   logic [31:0]   mem [256];
   int            ws_n = 0;
   bit            init_done = 1'b0;
   bit            dp_v;
   bit            dp_wr;
   logic [AW-1:0] dp_a;
   int            dp_cnt;

   assign HREADYOUT_S = !(dp_v && dp_cnt != 0);
   assign HRDATA_S    = (dp_v && !dp_wr) ? mem[dp_a[9:2]] : 32'h0;
   assign HRESP_S     = 1'b0;

   always @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         dp_v   <= 1'b0;
         dp_wr  <= 1'b0;
         dp_a   <= '0;
         dp_cnt <= 0;
         if (!init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i * 4);
            init_done <= 1'b1;
         end
      end else if (dp_v && dp_cnt != 0) begin
         dp_cnt <= dp_cnt - 1;
      end else begin
         if (dp_v && dp_wr) mem[dp_a[9:2]] <= HWDATA_S;
         if (HSEL_S && HREADY_S && HTRANS_S[1]) begin
            dp_v   <= 1'b1;
            dp_a   <= HADDR_S;
            dp_wr  <= HWRITE_S;
            dp_cnt <= ws_n;
         end else begin
            dp_v <= 1'b0;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Each master has at most one deferred request. The RAM can take a new
   // address only when it is ready. When both masters want the RAM, the one
   // that was not served most recently goes first. A master whose transfer
   // occupies the RAM sees the RAM's ready. Every other master is ready
   // unless it is waiting on a deferred request.
   bit            hold_v [2];
   logic [AW-1:0] hold_a [2];
   logic [2:0]    hold_s [2];
   logic          hold_w [2];
   int            owner_m     = -1;
   int            served_last = 1;

   always @(negedge HCLK) begin : cmp
      logic [1:0]    er, lv, want;
      int            win;
      logic [AW-1:0] e_a;
      logic [1:0]    e_t;
      logic [2:0]    e_s;
      logic          e_w;
      logic [31:0]   e_wd;
      if (HRESET) begin
         chk("rst_ready0", 32'(HREADYOUT0), 32'd1);
         chk("rst_ready1", 32'(HREADYOUT1), 32'd1);
         chk("rst_resp0", 32'(HRESP0), 32'd0);
         chk("rst_resp1", 32'(HRESP1), 32'd0);
         chk("rst_hsel_s", 32'(HSEL_S), 32'd0);
         chk("rst_htrans_s", 32'(HTRANS_S), 32'd0);
         chk("rst_hwdata_s", HWDATA_S, 32'd0);
         hold_v[0]   <= 1'b0;
         hold_v[1]   <= 1'b0;
         owner_m     <= -1;
         served_last <= 1;
      end else begin
         for (int x = 0; x < 2; x++) begin
            er[x]   = (owner_m == x) ? HREADYOUT_S : !hold_v[x];
            lv[x]   = bsel[x] && er[x] && btr[x][1];
            want[x] = hold_v[x] || lv[x];
         end
         win = -1;
         if (HREADYOUT_S) begin
            if (want[0] && want[1]) win = 1 - served_last;
            else if (want[0]) win = 0;
            else if (want[1]) win = 1;
         end
         e_a = '0; e_t = 2'b00; e_s = 3'b000; e_w = 1'b0;
         if (win >= 0) begin
            if (hold_v[win]) begin
               e_a = hold_a[win]; e_t = 2'b10; e_s = hold_s[win]; e_w = hold_w[win];
            end else begin
               e_a = badr[win]; e_t = btr[win]; e_s = bsz[win]; e_w = bwr[win];
            end
            $display("xfer m%0d addr=%h trans=%b write=%0d", win, e_a, e_t, e_w);
         end
         e_wd = (owner_m == 0) ? bwd[0] : (owner_m == 1) ? bwd[1] : 32'h0;
         chk("m_hsel_s", 32'(HSEL_S), 32'(win >= 0));
         chk("m_haddr_s", 32'(HADDR_S), 32'(e_a));
         chk("m_htrans_s", 32'(HTRANS_S), 32'(e_t));
         chk("m_hsize_s", 32'(HSIZE_S), 32'(e_s));
         chk("m_hwrite_s", 32'(HWRITE_S), 32'(e_w));
         chk("m_hwdata_s", HWDATA_S, e_wd);
         chk("m_ready0", 32'(HREADYOUT0), 32'(er[0]));
         chk("m_ready1", 32'(HREADYOUT1), 32'(er[1]));
         chk("m_resp0", 32'(HRESP0), 32'((owner_m == 0) && HRESP_S));
         chk("m_resp1", 32'(HRESP1), 32'((owner_m == 1) && HRESP_S));
         for (int x = 0; x < 2; x++) begin
            if (win == x) begin
               hold_v[x] <= 1'b0;
            end else if (lv[x]) begin
               hold_v[x] <= 1'b1;
               hold_a[x] <= badr[x];
               hold_s[x] <= bsz[x];
               hold_w[x] <= bwr[x];
            end
         end
         if (HREADYOUT_S) begin
            owner_m <= win;
            if (win >= 0) served_last <= win;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic set_m(input int m, input logic [1:0] t, input logic [AW-1:0] a,
                        input logic w, input logic [31:0] d);
      bsel[m] = 1'b1; btr[m] = t; badr[m] = a; bsz[m] = 3'b010; bwr[m] = w; bwd[m] = d;
   endtask

   task automatic idle(input int m);
      bsel[m] = 1'b0; btr[m] = 2'b00; badr[m] = '0; bwr[m] = 1'b0;
   endtask

   task automatic to_neg();
      @(negedge HCLK);
   endtask

   task automatic to_next();
      @(posedge HCLK);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      for (int m = 0; m < 2; m++) begin
         idle(m);
         bsz[m] = 3'b010;
         bwd[m] = 32'h0;
      end
      HRESET = 1'b1;
      repeat (2) @(posedge HCLK);
      #1 HRESET = 1'b0;

      // T1: M0 reads 0x0010 alone, no wait states.
      set_m(0, 2'b10, 16'h0010, 1'b0, 32'h0);
      to_neg();
      chk("t1_hsel_s", 32'(HSEL_S), 32'd1);
      chk("t1_htrans_s", 32'(HTRANS_S), 32'd2);
      chk("t1_haddr_s", 32'(HADDR_S), 32'h0010);
      chk("t1_ready1", 32'(HREADYOUT1), 32'd1);
      to_next();
      idle(0);
      to_neg();
      chk("t1_ready0", 32'(HREADYOUT0), 32'd1);
      chk("t1_rdata0", HRDATA0, 32'hA500_0010);
      to_next();

      // T2: both masters issue NONSEQ in the same cycle after reset.
      HRESET = 1'b1;
      to_next();
      HRESET = 1'b0;
      set_m(0, 2'b10, 16'h0040, 1'b0, 32'h0);
      set_m(1, 2'b10, 16'h0080, 1'b0, 32'h0);
      to_neg();
      chk("t2_first_m0", 32'(HADDR_S), 32'h0040);
      chk("t2_ready1_c0", 32'(HREADYOUT1), 32'd1);
      to_next();
      idle(0);
      idle(1);
      to_neg();
      chk("t2_ready1_stall", 32'(HREADYOUT1), 32'd0);
      chk("t2_replay_addr", 32'(HADDR_S), 32'h0080);
      chk("t2_replay_trans", 32'(HTRANS_S), 32'd2);
      chk("t2_rdata0", HRDATA0, 32'hA500_0040);
      to_next();

      // T3: both masters request every cycle; grants alternate starting with M0.
      for (int k = 0; k < 8; k++) begin
         set_m(0, 2'b10, 16'h0100 + 16'(k * 4), 1'b0, 32'h0);
         set_m(1, 2'b10, 16'h0200 + 16'(k * 4), 1'b0, 32'h0);
         to_neg();
         if (k == 0) begin
            chk("t2_ready1_done", 32'(HREADYOUT1), 32'd1);
            chk("t2_rdata1", HRDATA1, 32'hA500_0080);
         end
         chk("t3_hsel_s", 32'(HSEL_S), 32'd1);
         chk("t3_winner", 32'(HADDR_S[9:8]), (k % 2 == 0) ? 32'd1 : 32'd2);
         to_next();
      end
      idle(0);
      idle(1);
      repeat (3) to_next();

      // T4: 2 wait states; M1 writes while M0 requests mid-wait.
      ws_n = 2;
      set_m(1, 2'b10, 16'h0020, 1'b1, 32'hDEAD_BEEF);
      to_neg();
      chk("t4_hwrite_s", 32'(HWRITE_S), 32'd1);
      chk("t4_haddr_s", 32'(HADDR_S), 32'h0020);
      to_next();
      idle(1);
      set_m(0, 2'b10, 16'h0020, 1'b0, 32'h0);
      to_neg();
      chk("t4_busy_no_sel", 32'(HSEL_S), 32'd0);
      chk("t4_wdata_c1", HWDATA_S, 32'hDEAD_BEEF);
      chk("t4_ready1_wait", 32'(HREADYOUT1), 32'd0);
      to_next();
      idle(0);
      to_neg();
      chk("t4_ready0_held", 32'(HREADYOUT0), 32'd0);
      chk("t4_wdata_c2", HWDATA_S, 32'hDEAD_BEEF);
      to_next();
      to_neg();
      chk("t4_wdata_c3", HWDATA_S, 32'hDEAD_BEEF);
      chk("t4_ready1_done", 32'(HREADYOUT1), 32'd1);
      chk("t4_m0_replay", 32'(HADDR_S), 32'h0020);
      chk("t4_ready0_c3", 32'(HREADYOUT0), 32'd0);
      to_next();
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         to_neg();
         if (HREADYOUT0) seen = 1'b1;
         else to_next();
      end
      chk("t4_ready0_timeout", 32'(seen), 32'd1);
      chk("t4_readback", HRDATA0, 32'hDEAD_BEEF);
      to_next();
      ws_n = 0;
      to_next();

      // T5: M1 SEQ beat loses to M0 and is replayed as NONSEQ.
      set_m(1, 2'b10, 16'h0100, 1'b0, 32'h0);
      to_neg();
      chk("t5_m1_first", 32'(HADDR_S), 32'h0100);
      to_next();
      set_m(1, 2'b11, 16'h0104, 1'b0, 32'h0);
      set_m(0, 2'b10, 16'h0200, 1'b0, 32'h0);
      to_neg();
      chk("t5_m0_wins", 32'(HADDR_S), 32'h0200);
      to_next();
      idle(0);
      idle(1);
      to_neg();
      chk("t5_replay_nonseq", 32'(HTRANS_S), 32'd2);
      chk("t5_replay_addr", 32'(HADDR_S), 32'h0104);
      chk("t5_ready1_stall", 32'(HREADYOUT1), 32'd0);
      chk("t5_rdata0", HRDATA0, 32'hA500_0200);
      to_next();
      to_neg();
      chk("t5_rdata1", HRDATA1, 32'hA500_0104);
      to_next();

      // T6: reset while an M1 write sits in the hold register.
      set_m(0, 2'b10, 16'h0400, 1'b0, 32'h0);
      set_m(1, 2'b10, 16'h0300, 1'b1, 32'hBAD0_BAD0);
      to_neg();
      chk("t6_m0_wins", 32'(HADDR_S), 32'h0400);
      to_next();
      idle(1);
      set_m(0, 2'b10, 16'h0500, 1'b0, 32'h0);
      HRESET = 1'b1;
      to_neg();
      chk("t6_rst_ready1", 32'(HREADYOUT1), 32'd1);
      chk("t6_rst_gated", 32'(HSEL_S), 32'd0);
      to_next();
      HRESET = 1'b0;
      idle(0);
      to_next();
      set_m(0, 2'b10, 16'h0300, 1'b0, 32'h0);
      set_m(1, 2'b10, 16'h0304, 1'b0, 32'h0);
      to_neg();
      chk("t6_m0_first", 32'(HADDR_S), 32'h0300);
      to_next();
      idle(0);
      idle(1);
      to_neg();
      chk("t6_m1_second", 32'(HADDR_S), 32'h0304);
      chk("t6_ram_unchanged", HRDATA0, 32'hA500_0300);
      to_next();
      to_neg();
      chk("t6_rdata1", HRDATA1, 32'hA500_0304);
      to_next();
      repeat (2) to_next();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
